serial_word_feeder: RTL and testbench



---
 rtl/serial_word_feeder.sv | 137 +++++++++++++
 tb/tb_serial_word_feeder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// -----------------------------------------------------------------------------
// serial_word_feeder
//
// Parallel-to-serial stage that feeds a bit-serial sequence detector. A
// WIDTH-bit word is accepted through a start/ready handshake. The word is then
// emitted one bit per clock on j. Side-band status frames each word for the
// surrounding test logic.
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   rst      in   asynchronous, active-high reset
//   start    in   load request, accepted only while ready=1
//   din      in   WIDTH-bit word, sampled only on an accepted start
//   ready    out  block can accept start this cycle (IDLE or DONE)
//   j        out  serial data bit, forced to 0 outside a word
//   j_valid  out  j carries a word bit this cycle
//   busy     out  word currently being shifted
//   done     out  one-cycle pulse in the cycle after the last bit
//
// All outputs are Moore outputs decoded from the state and shift registers.
// They therefore take their reset values as soon as rst is asserted.
// -----------------------------------------------------------------------------
module serial_word_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             j,
    output logic             j_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             emit_bit_s;

    // State, shift register and bit counter; rst clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: load on accepted start, shift WIDTH times, then DONE.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    shreg_d = din;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Shift toward the emitted end so that the next bit appears in
                // the same position. Zeros fill the vacated end.
                if (MSB_FIRST) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output decode; j is gated so gaps between words are always 0.
    always_comb begin
        if (MSB_FIRST) begin
            emit_bit_s = shreg_q[WIDTH-1];
        end else begin
            emit_bit_s = shreg_q[0];
        end
        ready   = 1'b1;
        j       = 1'b0;
        j_valid = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_SHIFT: begin
                ready   = 1'b0;
                j       = emit_bit_s;
                j_valid = 1'b1;
                busy    = 1'b1;
            end
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
module tb_serial_word_feeder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [1:0]   start_v;
    logic [W-1:0] din_v [2];
    logic [1:0]   ready_w, j_w, jv_w, busy_w, done_w;

    int errors = 0;
    int checks = 0;

    // Instance 0 emits MSB first, instance 1 emits LSB first.
    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .start(start_v[0]), .din(din_v[0]),
        .ready(ready_w[0]), .j(j_w[0]), .j_valid(jv_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );

    serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .start(start_v[1]), .din(din_v[1]),
        .ready(ready_w[1]), .j(j_w[1]), .j_valid(jv_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. pos = -1 means idle. pos = 0..W-1 is the index of
    // the word bit on j. pos = W is the done/gap cycle.
    int           pos_m  [2] = '{-1, -1};
    logic [W-1:0] word_m [2];

    // Model update at each edge, with the same async reset as the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) pos_m[i] <= -1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pos_m[i] >= 0 && pos_m[i] < W) begin
                    pos_m[i] <= pos_m[i] + 1;
                end else if (start_v[i]) begin
                    word_m[i] <= din_v[i];
                    pos_m[i]  <= 0;
                end else begin
                    pos_m[i] <= -1;
                end
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic in_word;
            logic exp_j;
            in_word = (pos_m[i] >= 0 && pos_m[i] < W);
            exp_j   = 1'b0;
            if (in_word) exp_j = word_m[i][(i == 0) ? (W - 1 - pos_m[i]) : pos_m[i]];
            check($sformatf("model ready[%0d]", i), 32'(ready_w[i]), 32'(!in_word));
            check($sformatf("model j_valid[%0d]", i), 32'(jv_w[i]), 32'(in_word));
            check($sformatf("model busy[%0d]", i), 32'(busy_w[i]), 32'(in_word));
            check($sformatf("model done[%0d]", i), 32'(done_w[i]), 32'(pos_m[i] == W));
            check($sformatf("model j[%0d]", i), 32'(j_w[i]), 32'(exp_j));
        end
    end

    // Load one word, capture its 8 bits (first bit lands in cap[7]) and done.
    task automatic run_word(input int idx, input logic [W-1:0] d, input bit disturb,
                            output logic [W-1:0] cap, output logic dn9, output logic dn10);
        @(negedge clk);
        start_v[idx] = 1'b1;
        din_v[idx]   = d;
        @(negedge clk);
        start_v[idx] = 1'b0;
        for (int k = 0; k < W; k++) begin
            cap[W-1-k] = j_w[idx];
            if (disturb && k >= 2 && k <= 4) begin
                check("s4 ready during shift", 32'(ready_w[idx]), 32'd0);
                start_v[idx] = 1'b1;
                din_v[idx]   = ~d ^ W'(k);
            end else begin
                start_v[idx] = 1'b0;
            end
            @(negedge clk);
        end
        dn9 = done_w[idx];
        @(negedge clk);
        dn10 = done_w[idx];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] cap;
        logic [16:0]  cap17;
        logic         dn9, dn10;

        rst        = 1'b1;
        start_v    = 2'b00;
        din_v[0]   = '0;
        din_v[1]   = '0;
        #1;
        check("reset ready", 32'(ready_w[0]), 32'd1);
        check("reset j_valid", 32'(jv_w[0]), 32'd0);
        check("reset done", 32'(done_w[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Scenario 2: MSB first.
        run_word(0, 8'b1011_0000, 1'b0, cap, dn9, dn10);
        check("s2 bits", 32'(cap), 32'h000000B0);
        check("s2 done cycle9", 32'(dn9), 32'd1);
        check("s2 done cycle10", 32'(dn10), 32'd0);

        // Scenario 3: LSB first gives the same stream from 00001101.
        run_word(1, 8'b0000_1101, 1'b0, cap, dn9, dn10);
        check("s3 bits", 32'(cap), 32'h000000B0);
        check("s3 done cycle9", 32'(dn9), 32'd1);
        check("s3 done cycle10", 32'(dn10), 32'd0);

        // Scenario 4: start pulses and din changes while shifting are ignored.
        run_word(0, 8'b1011_0000, 1'b1, cap, dn9, dn10);
        check("s4 bits", 32'(cap), 32'h000000B0);
        check("s4 done cycle9", 32'(dn9), 32'd1);
        check("s4 done cycle10", 32'(dn10), 32'd0);

        // Scenario 5: start held high; A5, a single 0 gap, then 3C.
        @(negedge clk);
        start_v[0] = 1'b1;
        din_v[0]   = 8'hA5;
        @(negedge clk);
        din_v[0] = 8'h3C;
        for (int k = 0; k < 17; k++) begin
            cap17[16-k] = j_w[0];
            if (k == 8) begin
                check("s5 gap done", 32'(done_w[0]), 32'd1);
                check("s5 gap ready", 32'(ready_w[0]), 32'd1);
            end
            if (k == 9) begin
                check("s5 second word busy", 32'(busy_w[0]), 32'd1);
                start_v[0] = 1'b0;
            end
            @(negedge clk);
        end
        check("s5 stream", 32'(cap17), 32'({8'hA5, 1'b0, 8'h3C}));
        check("s5 final done", 32'(done_w[0]), 32'd1);
        @(negedge clk);

        // Scenario 6 and 1: reset during bit 4, checked before any clock edge.
        start_v[0] = 1'b1;
        din_v[0]   = 8'hC3;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("s6 bit4 valid", 32'(jv_w[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("s1 async ready", 32'(ready_w[0]), 32'd1);
        check("s1 async j", 32'(j_w[0]), 32'd0);
        check("s1 async j_valid", 32'(jv_w[0]), 32'd0);
        check("s1 async busy", 32'(busy_w[0]), 32'd0);
        check("s1 async done", 32'(done_w[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("s6 no done after abort", 32'(done_w[0]), 32'd0);
            @(negedge clk);
        end
        run_word(0, 8'h96, 1'b0, cap, dn9, dn10);
        check("s6 new word bits", 32'(cap), 32'h00000096);
        check("s6 new word done", 32'(dn9), 32'd1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
